// File: rtl/l1_relu_quant_serializer.sv
// l1_relu_quant_serializer
//   Consumer side of the layer-1 MAC accumulator bus. A start pulse in IDLE
//   snapshots every accumulator. Each one passes through ReLU, an arithmetic
//   right shift by SHIFT and saturation to signed OUT_W. The results are then
//   streamed one per valid/ready transfer toward layer 2. A packed copy of all
//   activations is built along the way and is complete when done pulses.
//
//   Handshake: a transfer happens on a rising edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low,
//   out_data, out_idx and out_last hold stable. out_valid never drops
//   without a transfer, except on reset.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           snapshot request, honoured only in IDLE
//   acc_in_packed   N_NEURONS signed ACC_W accumulators, lane j at [j*ACC_W +: ACC_W]
//   busy            high while emitting
//   out_valid       out_data/out_idx/out_last carry an element
//   out_ready       downstream accepts the element
//   out_data        activation of neuron out_idx, range 0..2^(OUT_W-1)-1
//   out_idx         neuron index of the current element
//   out_last        marks the element at index N_NEURONS-1
//   act_packed      activation j at [j*OUT_W +: OUT_W]
//   done            one-cycle pulse after the final transfer
module l1_relu_quant_serializer #(
  parameter int N_NEURONS = 32,
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 8,
  parameter int IDX_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_NEURONS*ACC_W-1:0] acc_in_packed,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic [N_NEURONS*OUT_W-1:0] act_packed,
  output logic                       done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int                      OUT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX   = ACC_W'(OUT_MAX_I);
  localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(N_NEURONS - 1);

  state_t                     state_q, state_d;
  // The snapshot is kept already quantised: the arithmetic is done once at
  // capture, so streaming is a plain read of a register file.
  logic [OUT_W-1:0]           snap_q [N_NEURONS];
  logic [IDX_W-1:0]           idx_q;
  logic [N_NEURONS*OUT_W-1:0] act_q;
  logic                       done_q;
  logic                       capture;
  logic                       xfer;
  logic                       last_xfer;

  // ReLU, then truncating arithmetic shift, then clamp to the positive
  // OUT_W range.
  function automatic logic [OUT_W-1:0] quant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (a < 0)             quant = '0;
    else if (s > OUT_MAX)  quant = OUT_MAX[OUT_W-1:0];
    else                   quant = s[OUT_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        xfer = out_ready;
        if (out_ready && (idx_q == LAST_IDX)) begin
          last_xfer = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_NEURONS; j++) snap_q[j] <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_xfer;
      if (capture) begin
        for (int j = 0; j < N_NEURONS; j++)
          snap_q[j] <= quant(acc_in_packed[j*ACC_W +: ACC_W]);
        idx_q <= '0;
        act_q <= '0;
      end else if (xfer) begin
        act_q[idx_q*OUT_W +: OUT_W] <= snap_q[idx_q];
        idx_q <= last_xfer ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q == EMIT);
  assign out_valid  = (state_q == EMIT);
  assign out_idx    = idx_q;
  assign out_data   = snap_q[idx_q];
  assign out_last   = (state_q == EMIT) && (idx_q == LAST_IDX);
  assign act_packed = act_q;
  assign done       = done_q;

endmodule

// File: tb/tb_l1_relu_quant_serializer.sv
module tb_l1_relu_quant_serializer;

  localparam int N = 32;
  localparam int AW = 20;
  localparam int OW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic [N*AW-1:0]   acc_bus;
  logic              busy, out_valid, out_last, done;
  logic [OW-1:0]     out_data;
  logic [4:0]        out_idx;
  logic [N*OW-1:0]   act_packed;

  logic signed [AW-1:0] accs [N];

  always_comb begin
    acc_bus = '0;
    for (int j = 0; j < N; j++) acc_bus[j*AW +: AW] = accs[j];
  end

  l1_relu_quant_serializer dut (
    .clk(clk), .rst(rst), .start(start), .acc_in_packed(acc_bus),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .act_packed(act_packed), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Quantisation from the arithmetic rule: negatives clip to 0, otherwise
  // divide by 256 (truncating) and clamp to 127.
  function automatic int ref_q(input int a);
    int v;
    if (a < 0) return 0;
    v = a / 256;
    return (v > 127) ? 127 : v;
  endfunction

  logic [OW-1:0] exp_q [$];       // elements still to be emitted, in order
  logic [OW-1:0] act_exp [N];
  logic [OW-1:0] got [N];         // what the DUT delivered per index
  bit            m_emit = 1'b0;
  int            m_idx  = 0;
  bit            m_done = 1'b0;

  function automatic logic [255:0] pack_act();
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*OW +: OW] = act_exp[j];
    return v;
  endfunction

  // ---------------- scoreboard: one compare per falling edge ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int j = 0; j < N; j++) act_exp[j] = '0;
      m_emit = 1'b0; m_idx = 0; m_done = 1'b0;
      chk("rst_valid", 256'(out_valid), 256'(0));
      chk("rst_busy",  256'(busy), 256'(0));
      chk("rst_done",  256'(done), 256'(0));
      chk("rst_act",   256'(act_packed), 256'(0));
    end else begin
      chk("valid", 256'(out_valid), 256'(m_emit));
      chk("busy",  256'(busy), 256'(m_emit));
      chk("done",  256'(done), 256'(m_done));
      chk("act",   256'(act_packed), pack_act());
      if (m_emit) begin
        chk("data", 256'(out_data), 256'(exp_q[0]));
        chk("idx",  256'(out_idx), 256'(m_idx));
        chk("last", 256'(out_last), 256'(m_idx == N - 1));
      end else begin
        chk("last_idle", 256'(out_last), 256'(0));
      end
      // advance to what the next rising edge must produce
      m_done = 1'b0;
      if (m_emit) begin
        if (out_ready) begin
          got[m_idx] = out_data;
          act_exp[m_idx] = exp_q.pop_front();
          m_idx++;
          if (m_idx == N) begin
            m_emit = 1'b0; m_idx = 0; m_done = 1'b1;
          end
        end
      end else if (start) begin
        exp_q.delete();
        for (int j = 0; j < N; j++) begin
          exp_q.push_back(OW'(ref_q(int'(accs[j]))));
          act_exp[j] = '0;
        end
        m_emit = 1'b1; m_idx = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_accs();
    int t;
    for (int j = 0; j < N; j++) begin
      case ($urandom_range(0, 3))
        0: t = int'($urandom_range(0, 20'hFFFFF));
        1: t = int'($urandom_range(0, 40000));
        2: t = -int'($urandom_range(1, 5000));
        default: t = int'($urandom_range(32400, 33100));
      endcase
      accs[j] = t[AW-1:0];
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready.
  // inject: start pulse plus new accumulators mid-frame.
  // chain: on seeing done, raise start in that same cycle.
  task automatic run_frame(input int mode, input bit do_start, input bit inject,
                           input bit chain, output int ncyc);
    if (do_start) begin
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
    end
    ncyc = 0;
    forever begin
      @(posedge clk); #1;
      start = 1'b0;
      ncyc++;
      if (ncyc == 1) chk("first_valid", 256'(out_valid), 256'(1));
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((ncyc - 1) % 3 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject && ncyc == 5) begin
        start = 1'b1;
        rand_accs();
      end
      if (done) begin
        if (chain) start = 1'b1;
        break;
      end
      if (ncyc > 400) begin
        chk("frame_timeout", 256'(ncyc), 256'(0));
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int ncyc;
  logic [255:0] lit;
  localparam int T1 [7] = '{0, 0, 1, 127, 127, 127, 0};

  initial begin
    for (int j = 0; j < N; j++) accs[j] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. quantisation vectors
    rand_accs();
    accs[0] = 20'h00000; accs[1] = 20'hFFFFF; accs[2] = 20'h00180;
    accs[3] = 20'h07FFF; accs[4] = 20'h08000; accs[5] = 20'h7FFFF;
    accs[6] = 20'h80000;
    run_frame(0, 1'b1, 1'b0, 1'b0, ncyc);
    for (int j = 0; j < 7; j++) chk($sformatf("t1_lane%0d", j), 256'(got[j]), 256'(T1[j]));

    // 2. full frame, ready high, exact latency
    for (int j = 0; j < N; j++) accs[j] = AW'(j * 256);
    run_frame(0, 1'b1, 1'b0, 1'b0, ncyc);
    chk("t2_cycles_to_done", 256'(ncyc), 256'(33));
    lit = '0;
    for (int j = 0; j < N; j++) lit[j*OW +: OW] = OW'(j);
    chk("t2_act_packed", 256'(act_packed), lit);
    chk("t2_data5", 256'(got[5]), 256'(5));
    chk("t2_data31", 256'(got[31]), 256'(31));

    // 3. backpressure 1,0,0,...
    rand_accs();
    run_frame(1, 1'b1, 1'b0, 1'b0, ncyc);
    chk("t3_act_complete", 256'(act_packed), pack_act());

    // 4. start mid-frame ignored; start in done cycle begins next frame
    rand_accs();
    run_frame(0, 1'b1, 1'b1, 1'b1, ncyc);
    rand_accs();
    run_frame(2, 1'b0, 1'b0, 1'b0, ncyc);

    // random frames
    for (int f = 0; f < 4; f++) begin
      rand_accs();
      run_frame(2, 1'b1, f[0], 1'b0, ncyc);
    end

    // 5. async reset at idx 10
    rand_accs();
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_idx_before", 256'(out_idx), 256'(10));
    #2 rst = 1'b1;
    #1;
    chk("t5_valid_now", 256'(out_valid), 256'(0));
    chk("t5_busy_now",  256'(busy), 256'(0));
    chk("t5_act_now",   256'(act_packed), 256'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", 256'(done), 256'(0));
    rand_accs();
    run_frame(0, 1'b1, 1'b0, 1'b0, ncyc);
    chk("t5_refill_cycles", 256'(ncyc), 256'(33));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
